// File: rtl/avg_pkg.sv
// Shared definitions for the averaging scheduler: FSM encoding and id-width helper.
// Pure declarations, no logic; imported by the scheduler and its interface.
package avg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to index n items; never less than 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/avg_sched_if.sv
// Requester/consumer bundle for avg_sched: packed operand pairs in, tagged result out.
// Valid/ready on both sides; req_ready is a one-hot grant.
interface avg_sched_if #(
  parameter int W    = 4,
  parameter int NREQ = 4
);
  localparam int IDW = avg_pkg::clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [W-1:0]      res_data;
  logic [IDW-1:0]    res_id;
  logic              res_ready;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/avg_unit.sv
// Combinational overflow-safe adder for the average: sum = a + b + ROUND at W+1 bits.
// Zero latency, no flow control; the caller takes sum[W:1] as the average.
module avg_unit #(
  parameter int W     = 4,
  parameter int ROUND = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  localparam logic [W:0] RND = (ROUND != 0) ? (W+1)'(1) : '0;

  assign sum = {1'b0, a} + {1'b0, b} + RND;

endmodule

// File: rtl/avg_sched.sv
// Round-robin shares one averaging unit among NREQ requesters; result tagged with id.
// Grant at N -> res_valid at N+2; a stalled consumer holds DONE and blocks new grants.
module avg_sched
  import avg_pkg::*;
#(
  parameter int W     = 4,
  parameter int NREQ  = 4,
  parameter int ROUND = 0
) (
  input logic        clk,
  input logic        rst,
  avg_sched_if.slave bus
);

  localparam int IDW = clog2(NREQ);

  state_t         state_q, state_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W:0]     sum_q, sum_d;
  logic [W:0]     unit_sum;
  logic [IDW-1:0] win;
  logic           grant_vld;
  logic [NREQ-1:0] req_ready;
  logic           res_valid;

  // First valid index strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] vld,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic           found;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!found && vld[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign win       = rr_pick(bus.req_valid, ptr_q);
  assign grant_vld = (state_q == IDLE) && (|bus.req_valid);

  avg_unit #(.W(W), .ROUND(ROUND)) u_avg_unit (
    .a   (op_a_q),
    .b   (op_b_q),
    .sum (unit_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req_valid) state_d = CALC;
      CALC:    state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst so nothing is granted or emitted while an in-flight op is flushed.
  always_comb begin
    req_ready = '0;
    res_valid = 1'b0;
    if (!rst) begin
      if (grant_vld) begin
        req_ready[win] = 1'b1;
      end
      res_valid = (state_q == DONE);
    end
  end

  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
    sum_d  = sum_q;
    if (grant_vld) begin
      op_a_d = bus.req_a[win*W +: W];
      op_b_d = bus.req_b[win*W +: W];
      id_d   = win;
      ptr_d  = win;
    end
    if (state_q == CALC) begin
      sum_d = unit_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
      id_q   <= '0;
      ptr_q  <= IDW'(NREQ - 1);
      sum_q  <= '0;
    end else begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      id_q   <= id_d;
      ptr_q  <= ptr_d;
      sum_q  <= sum_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = sum_q[W:1];
  assign bus.res_id    = id_q;

endmodule

// File: tb/tb_avg_sched.sv
// Directed bench for avg_sched: truncating and rounding instances share one stimulus.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_avg_sched;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  avg_sched_if #(.W(4), .NREQ(4)) if0 ();
  avg_sched_if #(.W(4), .NREQ(4)) if1 ();

  assign if1.req_valid = if0.req_valid;
  assign if1.req_a     = if0.req_a;
  assign if1.req_b     = if0.req_b;
  assign if1.res_ready = if0.res_ready;

  avg_sched #(.W(4), .NREQ(4), .ROUND(0)) u_dut_trunc (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  avg_sched #(.W(4), .NREQ(4), .ROUND(1)) u_dut_round (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    if0.req_a[i*4 +: 4] = a;
    if0.req_b[i*4 +: 4] = b;
  endtask

  task automatic chk_res(input string tag, input int id, input logic [3:0] e0,
                         input logic [3:0] e1);
    chk($sformatf("%s_vld", tag), if0.res_valid, 1);
    chk($sformatf("%s_vld_r", tag), if1.res_valid, 1);
    chk($sformatf("%s_dat_t", tag), if0.res_data, e0);
    chk($sformatf("%s_dat_r", tag), if1.res_data, e1);
    chk($sformatf("%s_id", tag), if0.res_id, id);
  endtask

  // One isolated transaction from requester i with an always-ready consumer.
  task automatic single(input string tag, input int i, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] e0, input logic [3:0] e1);
    logic [3:0] onehot;
    onehot = 4'b0001 << i;
    @(negedge clk);
    if0.req_valid = onehot;
    if0.res_ready = 1'b1;
    set_op(i, a, b);
    #1;
    chk($sformatf("%s_grant", tag), if0.req_ready, onehot);
    @(negedge clk);
    if0.req_valid = '0;
    #1;
    chk($sformatf("%s_calc_rdy", tag), if0.req_ready, 0);
    chk($sformatf("%s_calc_vld", tag), if0.res_valid, 0);
    @(negedge clk);
    #1;
    chk_res(tag, i, e0, e1);
    @(negedge clk);
    #1;
    chk($sformatf("%s_after_vld", tag), if0.res_valid, 0);
  endtask

  logic [3:0] t3_a [4] = '{4'd2, 4'd5, 4'd9, 4'd14};
  logic [3:0] t3_b [4] = '{4'd4, 4'd7, 4'd1, 4'd13};
  logic [3:0] t3_e0[4] = '{4'd3, 4'd6, 4'd5, 4'd13};
  logic [3:0] t3_e1[4] = '{4'd3, 4'd6, 4'd5, 4'd14};

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    if0.req_valid = 4'b1111;
    if0.req_a     = '0;
    if0.req_b     = '0;
    if0.res_ready = 1'b0;

    // Reset: outputs cleared and no grant despite every requester valid.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdy", if0.req_ready, 0);
    chk("rst_vld", if0.res_valid, 0);
    chk("rst_dat", if0.res_data, 0);
    chk("rst_id", if0.res_id, 0);
    rst           = 1'b0;
    if0.req_valid = '0;

    single("t1", 0, 4'd15, 4'd1, 4'd8, 4'd8);
    single("t2a", 0, 4'd15, 4'd0, 4'd7, 4'd8);
    single("t2b", 0, 4'd15, 4'd15, 4'd15, 4'd15);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // All four valid: grants rotate 0,1,2,3,0 three cycles apart.
    @(negedge clk);
    if0.req_valid = 4'b1111;
    if0.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, t3_a[i], t3_b[i]);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      chk($sformatf("t3_grant%0d", k), if0.req_ready, 4'b0001 << (k % 4));
      @(negedge clk);
      #1;
      chk($sformatf("t3_calc%0d", k), if0.req_ready, 0);
      @(negedge clk);
      #1;
      chk_res($sformatf("t3_res%0d", k), k % 4, t3_e0[k % 4], t3_e1[k % 4]);
    end
    @(negedge clk);
    if0.req_valid = '0;

    // Consumer stall: result held, no new grant while another requester waits.
    @(negedge clk);
    if0.req_valid = 4'b1000;
    if0.res_ready = 1'b0;
    set_op(3, 4'd9, 4'd6);
    #1;
    chk("t4_grant", if0.req_ready, 4'b1000);
    @(negedge clk);
    if0.req_valid = '0;
    #1;
    chk("t4_calc_vld", if0.res_valid, 0);
    @(negedge clk);
    if0.req_valid = 4'b0001;
    for (int s = 0; s < 5; s++) begin
      if (s != 0) @(negedge clk);
      #1;
      chk_res($sformatf("t4_stall%0d", s), 3, 4'd7, 4'd8);
      chk($sformatf("t4_stall%0d_rdy", s), if0.req_ready, 0);
    end
    @(negedge clk);
    if0.res_ready = 1'b1;
    if0.req_valid = '0;
    #1;
    chk_res("t4_release", 3, 4'd7, 4'd8);
    @(negedge clk);
    #1;
    chk("t4_after_vld", if0.res_valid, 0);

    // Reset during CALC discards the result and restarts priority at requester 0.
    @(negedge clk);
    if0.req_valid = 4'b0100;
    set_op(2, 4'd12, 4'd13);
    #1;
    chk("t5_grant2", if0.req_ready, 4'b0100);
    @(negedge clk);
    rst           = 1'b1;
    if0.req_valid = '0;
    #1;
    chk("t5_rst_rdy", if0.req_ready, 0);
    chk("t5_rst_vld", if0.res_valid, 0);
    @(negedge clk);
    rst           = 1'b0;
    if0.req_valid = 4'b1010;
    set_op(1, 4'd3, 4'd4);
    set_op(3, 4'd1, 4'd1);
    #1;
    chk("t5_post_vld", if0.res_valid, 0);
    chk("t5_grant1", if0.req_ready, 4'b0010);
    @(negedge clk);
    if0.req_valid = '0;
    #1;
    chk("t5_calc_vld", if0.res_valid, 0);
    @(negedge clk);
    #1;
    chk_res("t5_res", 1, 4'd3, 4'd4);
    @(negedge clk);
    #1;
    chk("t5_after_vld", if0.res_valid, 0);

    // Wrap search: with ptr=3 only requester 2 valid is granted at once.
    single("t6a", 3, 4'd0, 4'd0, 4'd0, 4'd0);
    single("t6b", 2, 4'd10, 4'd11, 4'd10, 4'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
